pe_mem_arbiter: RTL

Shares the single CPU-side port of the processing element's dual-port RAM between the core's data bus and a second DMA-class requester, such as the DDMA prefetch path. It sits between the core/MMIO address decode and port B of the PE RAM. Each cycle it grants at most one access. The CPU is stalled whenever it loses arbitration, and the DMA requester may burst up to a bounded length before the CPU is served. Read data is returned one cycle after issue, steered to the requester that issued the read.

---
 rtl/pe_arb_pkg.sv | 13 +
 rtl/pe_mem_arbiter_if.sv | 47 ++++
 rtl/pe_mem_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/pe_arb_pkg.sv
// Shared types and defaults for the PE RAM port-B arbiter.
// Owner encoding records who received the most recent grant.
package pe_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CPU_OWN = 2'd1,
      DMA_OWN = 2'd2
   } owner_t;

   localparam int DEFAULT_MAX_BURST = 8;

endpackage

// File: rtl/pe_mem_arbiter_if.sv
// Bundle of CPU, DMA and RAM-side signals around the port-B arbiter.
// Signal directions are named from the arbiter's point of view.
interface pe_mem_arbiter_if #(
   parameter int MEMORY_WIDTH = 32,
   parameter int ADDR_WIDTH   = 32
);
   logic                    cpu_req_in;
   logic                    cpu_wb_in;
   logic [ADDR_WIDTH-1:0]   cpu_addr_in;
   logic [MEMORY_WIDTH-1:0] cpu_data_in;
   logic                    cpu_stall_out;
   logic                    cpu_rvalid_out;

   logic                    dma_req_in;
   logic                    dma_wb_in;
   logic [ADDR_WIDTH-1:0]   dma_addr_in;
   logic [MEMORY_WIDTH-1:0] dma_data_in;
   logic                    dma_gnt_out;
   logic                    dma_rvalid_out;

   logic                    mem_enable_out;
   logic                    mem_wb_out;
   logic [ADDR_WIDTH-1:0]   mem_addr_out;
   logic [MEMORY_WIDTH-1:0] mem_data_out;
   logic [MEMORY_WIDTH-1:0] mem_data_in;
   logic [MEMORY_WIDTH-1:0] rdata_out;

   modport slave (
      input  cpu_req_in, cpu_wb_in, cpu_addr_in, cpu_data_in,
      output cpu_stall_out, cpu_rvalid_out,
      input  dma_req_in, dma_wb_in, dma_addr_in, dma_data_in,
      output dma_gnt_out, dma_rvalid_out,
      output mem_enable_out, mem_wb_out, mem_addr_out, mem_data_out,
      input  mem_data_in,
      output rdata_out
   );

   modport master (
      output cpu_req_in, cpu_wb_in, cpu_addr_in, cpu_data_in,
      input  cpu_stall_out, cpu_rvalid_out,
      output dma_req_in, dma_wb_in, dma_addr_in, dma_data_in,
      input  dma_gnt_out, dma_rvalid_out,
      input  mem_enable_out, mem_wb_out, mem_addr_out, mem_data_out,
      output mem_data_in,
      input  rdata_out
   );
endinterface

// File: rtl/pe_mem_arbiter.sv
// Arbitrates PE RAM port B between the core data bus and a DMA-class requester.
// One grant per cycle, bounded DMA bursts, read data tagged back one cycle later.
module pe_mem_arbiter
   import pe_arb_pkg::*;
#(
   parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
   input logic             clock,
   input logic             reset,
   pe_mem_arbiter_if.slave bus
);

   localparam int                 CNT_W   = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(MAX_BURST);
   localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);

   owner_t           state_q, state_d;
   logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
   logic             cpu_rvalid_q, cpu_rvalid_d;
   logic             dma_rvalid_q, dma_rvalid_d;
   logic             cpu_req_s, dma_req_s;
   logic             cpu_win_s, dma_win_s;

   // Winner selection, next owner/burst/tag state and the RAM-side mux.
   always_comb begin
      cpu_win_s    = 1'b0;
      dma_win_s    = 1'b0;
      state_d      = IDLE;
      burst_cnt_d  = '0;
      cpu_rvalid_d = 1'b0;
      dma_rvalid_d = 1'b0;

      // While the CPU's read data is returning, its still-held request is the
      // completion of that read, not a new access.
      cpu_req_s = bus.cpu_req_in & ~cpu_rvalid_q & ~reset;
      dma_req_s = bus.dma_req_in & ~reset;

      if (cpu_req_s && dma_req_s) begin
         case (state_q)
            CPU_OWN: dma_win_s = 1'b1;
            DMA_OWN: begin
               if (burst_cnt_q < CNT_MAX) begin
                  dma_win_s = 1'b1;
               end else begin
                  cpu_win_s = 1'b1;
               end
            end
            default: cpu_win_s = 1'b1;
         endcase
      end else if (cpu_req_s) begin
         cpu_win_s = 1'b1;
      end else if (dma_req_s) begin
         dma_win_s = 1'b1;
      end else begin
         cpu_win_s = 1'b0;
      end

      if (cpu_win_s) begin
         state_d = CPU_OWN;
      end else if (dma_win_s) begin
         state_d = DMA_OWN;
      end else begin
         state_d = IDLE;
      end

      if (dma_win_s) begin
         if (state_q != DMA_OWN) begin
            burst_cnt_d = CNT_ONE;
         end else if (burst_cnt_q == CNT_MAX) begin
            burst_cnt_d = CNT_MAX;
         end else begin
            burst_cnt_d = burst_cnt_q + CNT_ONE;
         end
      end else begin
         burst_cnt_d = '0;
      end

      cpu_rvalid_d = cpu_win_s & ~bus.cpu_wb_in;
      dma_rvalid_d = dma_win_s & ~bus.dma_wb_in;

      bus.mem_enable_out = cpu_win_s | dma_win_s;
      if (cpu_win_s) begin
         bus.mem_wb_out   = bus.cpu_wb_in;
         bus.mem_addr_out = bus.cpu_addr_in;
         bus.mem_data_out = bus.cpu_data_in;
      end else if (dma_win_s) begin
         bus.mem_wb_out   = bus.dma_wb_in;
         bus.mem_addr_out = bus.dma_addr_in;
         bus.mem_data_out = bus.dma_data_in;
      end else begin
         bus.mem_wb_out   = 1'b0;
         bus.mem_addr_out = '0;
         bus.mem_data_out = '0;
      end

      // A granted CPU read keeps the stall up until its data cycle.
      bus.cpu_stall_out  = cpu_req_s & (~cpu_win_s | ~bus.cpu_wb_in);
      bus.dma_gnt_out    = dma_win_s;
      bus.cpu_rvalid_out = cpu_rvalid_q;
      bus.dma_rvalid_out = dma_rvalid_q;
      bus.rdata_out      = bus.mem_data_in;
   end

   // Owner state, DMA burst counter and read-return tags.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         burst_cnt_q  <= '0;
         cpu_rvalid_q <= 1'b0;
         dma_rvalid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         burst_cnt_q  <= burst_cnt_d;
         cpu_rvalid_q <= cpu_rvalid_d;
         dma_rvalid_q <= dma_rvalid_d;
      end
   end

endmodule
